// File: rtl/wb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_cdb_arbiter
//   Write-back arbiter in front of the common data bus (CDB). It collects the
//   results of the single-cycle ALU and the 2-stage MUL unit and broadcasts at
//   most one of them per cycle to the PRF/ROB. Results that cannot go out in
//   the cycle they arrive are parked in a small in-order FIFO. When the FIFO
//   is nearly full, freeze_back stalls both producers.
//
//   Broadcast order is acceptance order. Within one cycle the MUL result is
//   taken before the ALU result, because the MUL instruction is the older one.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous, active-low reset
//   Result_alu        ALU result data
//   tag_PRF_alu       ALU destination physical register tag
//   tag_ROB_alu       ALU reorder-buffer index
//   valid_Result_alu  ALU result valid
//   Result_mul        MUL result data
//   tag_PRF_mul       MUL destination physical register tag
//   tag_ROB_mul       MUL reorder-buffer index
//   valid_Result_mul  MUL result valid
//   cdb_valid         registered broadcast valid
//   cdb_result        registered broadcast data (holds when idle)
//   cdb_tag_PRF       registered broadcast PRF tag (holds when idle)
//   cdb_tag_ROB       registered broadcast ROB tag (holds when idle)
//   freeze_back       producer stall, decoded from the registered FIFO count
// ---------------------------------------------------------------------------
module wb_cdb_arbiter #(
  parameter int DATA_W = 16,
  parameter int PRF_W  = 5,
  parameter int ROB_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Result_alu,
  input  logic [PRF_W-1:0]  tag_PRF_alu,
  input  logic [ROB_W-1:0]  tag_ROB_alu,
  input  logic              valid_Result_alu,
  input  logic [DATA_W-1:0] Result_mul,
  input  logic [PRF_W-1:0]  tag_PRF_mul,
  input  logic [ROB_W-1:0]  tag_ROB_mul,
  input  logic              valid_Result_mul,
  output logic              cdb_valid,
  output logic [DATA_W-1:0] cdb_result,
  output logic [PRF_W-1:0]  cdb_tag_PRF,
  output logic [ROB_W-1:0]  cdb_tag_ROB,
  output logic              freeze_back
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PRF_W-1:0]  prf;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  // Pending-result storage. The data array carries no reset: an entry is
  // only ever read after it has been written, and count guards that.
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  wr_ptr_p1;
  logic [CNT_W-1:0]  count_nxt;

  entry_t            mul_e;
  entry_t            alu_e;
  entry_t            head_e;
  entry_t            send_e;
  entry_t            enq0_e;
  entry_t            enq1_e;

  logic              mul_acc;
  logic              alu_acc;
  logic              fifo_empty;
  logic              send;
  logic              deq;
  logic              enq0_vld;
  logic              enq1_vld;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stall is decoded from the registered count only, so there is no
  // combinational path from the valid inputs to freeze_back. A threshold of
  // DEPTH-1 leaves room for the worst case of two enqueues and one dequeue
  // in the last accepting cycle, so the FIFO cannot overflow.
  assign freeze_back = (count >= CNT_W'(DEPTH - 1));

  // While frozen the producers hold their outputs; ignoring the valids here
  // is what keeps a held result from being captured twice.
  assign mul_acc    = valid_Result_mul & ~freeze_back;
  assign alu_acc    = valid_Result_alu & ~freeze_back;
  assign fifo_empty = (count == '0);

  assign mul_e  = '{data: Result_mul, prf: tag_PRF_mul, rob: tag_ROB_mul};
  assign alu_e  = '{data: Result_alu, prf: tag_PRF_alu, rob: tag_ROB_alu};
  assign head_e = mem[rd_ptr];

  assign wr_ptr_p1 = ptr_inc(wr_ptr);

  // Selection: with an empty FIFO the oldest accepted result bypasses straight
  // to the CDB register. Otherwise the FIFO head goes out and everything
  // accepted this cycle lines up behind it, MUL first.
  always_comb begin
    send     = 1'b0;
    deq      = 1'b0;
    send_e   = head_e;
    enq0_vld = 1'b0;
    enq1_vld = 1'b0;
    enq0_e   = mul_e;
    enq1_e   = alu_e;

    if (fifo_empty) begin
      if (mul_acc) begin
        send   = 1'b1;
        send_e = mul_e;
        if (alu_acc) begin
          enq0_vld = 1'b1;
          enq0_e   = alu_e;
        end
      end else if (alu_acc) begin
        send   = 1'b1;
        send_e = alu_e;
      end
    end else begin
      send   = 1'b1;
      deq    = 1'b1;
      send_e = head_e;
      if (mul_acc && alu_acc) begin
        enq0_vld = 1'b1;
        enq0_e   = mul_e;
        enq1_vld = 1'b1;
        enq1_e   = alu_e;
      end else if (mul_acc) begin
        enq0_vld = 1'b1;
        enq0_e   = mul_e;
      end else if (alu_acc) begin
        enq0_vld = 1'b1;
        enq0_e   = alu_e;
      end
    end
  end

  always_comb begin
    rd_ptr_nxt = deq ? ptr_inc(rd_ptr) : rd_ptr;
    if (enq1_vld) begin
      wr_ptr_nxt = ptr_inc(wr_ptr_p1);
    end else if (enq0_vld) begin
      wr_ptr_nxt = wr_ptr_p1;
    end else begin
      wr_ptr_nxt = wr_ptr;
    end
    count_nxt = count + CNT_W'(enq0_vld) + CNT_W'(enq1_vld) - CNT_W'(deq);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (enq0_vld) begin
      mem[wr_ptr] <= enq0_e;
    end
    if (enq1_vld) begin
      mem[wr_ptr_p1] <= enq1_e;
    end
  end

  // Payload holds its last value on idle cycles; only the valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid   <= 1'b0;
      cdb_result  <= '0;
      cdb_tag_PRF <= '0;
      cdb_tag_ROB <= '0;
    end else if (send) begin
      cdb_valid   <= 1'b1;
      cdb_result  <= send_e.data;
      cdb_tag_PRF <= send_e.prf;
      cdb_tag_ROB <= send_e.rob;
    end else begin
      cdb_valid   <= 1'b0;
    end
  end

endmodule
